// File: rtl/sad_search_ctrl.sv
// sad_search_ctrl
//   Sequencer for the SAD motion-search datapath. It loads a WIN_DIM x WIN_DIM
//   window into a local buffer, then raster-scans every window-sized position
//   of a FRAME_DIM x FRAME_DIM frame. For each position it accumulates
//   |frame - window| and keeps the lowest SAD with its row/col.
// Ports
//   Clk, Reset            clock, synchronous active-high reset
//   Start                 begin a search (accepted only when idle)
//   FrameBase, WinBase    word addresses of frame/window pixel (0,0), latched with Start
//   MemReq, MemAddr       read request; address held stable until MemValid
//   MemValid, MemRdData   read completion and data (pixel in the low PIX_W bits)
//   Busy, Done            search in progress / one-cycle completion pulse
//   CurrentSAD            SAD of the most recently completed position
//   LowestSAD, BestRow, BestCol   best result of the current search
module sad_search_ctrl #(
  parameter int FRAME_DIM = 16,
  parameter int WIN_DIM   = 4,
  parameter int ADDR_W    = 32,
  parameter int PIX_W     = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] FrameBase,
  input  logic [ADDR_W-1:0] WinBase,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemValid,
  input  logic [31:0]       MemRdData,
  output logic              Busy,
  output logic              Done,
  output logic [31:0]       CurrentSAD,
  output logic [31:0]       LowestSAD,
  output logic [7:0]        BestRow,
  output logic [7:0]        BestCol
);

  localparam int NPOS  = FRAME_DIM - WIN_DIM + 1;
  localparam int IW    = (WIN_DIM > 1) ? $clog2(WIN_DIM) : 1;
  localparam int BW    = (WIN_DIM * WIN_DIM > 1) ? $clog2(WIN_DIM * WIN_DIM) : 1;
  localparam int BUF_N = 1 << BW;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SCAN = 3'd2;
  localparam logic [2:0] S_CMP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [IW-1:0] IJ_LAST  = IW'(WIN_DIM - 1);
  localparam logic [7:0]    POS_LAST = 8'(NPOS - 1);

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    logic [PIX_W-1:0] d;
    if (a >= b) d = a - b;
    else        d = b - a;
    return d;
  endfunction

  // Accumulator saturates at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [PIX_W-1:0] d);
    logic [32:0] sum;
    sum = {1'b0, acc} + 33'(d);
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  function automatic logic [ADDR_W-1:0] win_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [IW-1:0] i,
                                                 input logic [IW-1:0] j);
    return base + ADDR_W'(32'(i) * 32'(WIN_DIM) + 32'(j));
  endfunction

  function automatic logic [ADDR_W-1:0] frame_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [7:0] r, input logic [7:0] c,
                                                   input logic [IW-1:0] i,
                                                   input logic [IW-1:0] j);
    return base + ADDR_W'((32'(r) + 32'(i)) * 32'(FRAME_DIM) + 32'(c) + 32'(j));
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] frame_base_q, frame_base_d, win_base_q, win_base_d;
  logic [IW-1:0]     i_q, i_d, j_q, j_d;
  logic [7:0]        r_q, r_d, c_q, c_d;
  logic [31:0]       acc_q, acc_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [31:0]       cur_sad_q, cur_sad_d, low_sad_q, low_sad_d;
  logic [7:0]        best_row_q, best_row_d, best_col_q, best_col_d;
  logic [PIX_W-1:0]  win_q [BUF_N];

  logic              cap_s, last_ij_s, last_pos_s, win_we_s;
  logic [IW-1:0]     ni_s, nj_s;
  logic [7:0]        nr_s, nc_s;
  logic [BW-1:0]     widx_s;
  logic [PIX_W-1:0]  pix_s, wpix_s;
  logic              unused_s;

  assign unused_s = ^MemRdData[31:PIX_W];

  // Handshake capture and raster increments of window and position indices.
  always_comb begin
    cap_s      = mem_req_q & MemValid;
    last_ij_s  = (i_q == IJ_LAST) && (j_q == IJ_LAST);
    last_pos_s = (r_q == POS_LAST) && (c_q == POS_LAST);
    if (j_q == IJ_LAST) begin
      nj_s = '0;
      ni_s = i_q + IW'(1);
    end else begin
      nj_s = j_q + IW'(1);
      ni_s = i_q;
    end
    if (c_q == POS_LAST) begin
      nc_s = 8'd0;
      nr_s = r_q + 8'd1;
    end else begin
      nc_s = c_q + 8'd1;
      nr_s = r_q;
    end
    widx_s = BW'(32'(i_q) * 32'(WIN_DIM) + 32'(j_q));
    pix_s  = MemRdData[PIX_W-1:0];
    wpix_s = win_q[widx_s];
  end

  // Next-state logic of the search sequencer.
  always_comb begin
    state_d      = state_q;
    frame_base_d = frame_base_q;
    win_base_d   = win_base_q;
    i_d          = i_q;
    j_d          = j_q;
    r_d          = r_q;
    c_d          = c_q;
    acc_d        = acc_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cur_sad_d    = cur_sad_q;
    low_sad_d    = low_sad_q;
    best_row_d   = best_row_q;
    best_col_d   = best_col_q;
    win_we_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d      = S_LOAD;
          frame_base_d = FrameBase;
          win_base_d   = WinBase;
          low_sad_d    = 32'hFFFF_FFFF;
          best_row_d   = 8'd0;
          best_col_d   = 8'd0;
          i_d          = '0;
          j_d          = '0;
          r_d          = 8'd0;
          c_d          = 8'd0;
          busy_d       = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // First LOAD cycle only sets up the request from the latched base.
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_addr_d = win_addr(win_base_q, '0, '0);
        end else if (cap_s) begin
          win_we_s = 1'b1;
          if (last_ij_s) begin
            state_d    = S_SCAN;
            i_d        = '0;
            j_d        = '0;
            acc_d      = 32'd0;
            mem_addr_d = frame_addr(frame_base_q, r_q, c_q, '0, '0);
          end else begin
            i_d        = ni_s;
            j_d        = nj_s;
            mem_addr_d = win_addr(win_base_q, ni_s, nj_s);
          end
        end else begin
          mem_req_d = 1'b1;
        end
      end
      S_SCAN: begin
        if (cap_s) begin
          acc_d = sat_add(acc_q, abs_diff(pix_s, wpix_s));
          if (last_ij_s) begin
            state_d   = S_CMP;
            mem_req_d = 1'b0;
          end else begin
            i_d        = ni_s;
            j_d        = nj_s;
            mem_addr_d = frame_addr(frame_base_q, r_q, c_q, ni_s, nj_s);
          end
        end else begin
          mem_req_d = 1'b1;
        end
      end
      S_CMP: begin
        cur_sad_d = acc_q;
        // Strict compare: ties keep the earlier raster position.
        if (acc_q < low_sad_q) begin
          low_sad_d  = acc_q;
          best_row_d = r_q;
          best_col_d = c_q;
        end else begin
          low_sad_d = low_sad_q;
        end
        if (last_pos_s) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = S_SCAN;
          r_d        = nr_s;
          c_d        = nc_s;
          i_d        = '0;
          j_d        = '0;
          acc_d      = 32'd0;
          mem_req_d  = 1'b1;
          mem_addr_d = frame_addr(frame_base_q, nr_s, nc_s, '0, '0);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      frame_base_q <= '0;
      win_base_q   <= '0;
      i_q          <= '0;
      j_q          <= '0;
      r_q          <= 8'd0;
      c_q          <= 8'd0;
      acc_q        <= 32'd0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cur_sad_q    <= 32'd0;
      low_sad_q    <= 32'hFFFF_FFFF;
      best_row_q   <= 8'd0;
      best_col_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      frame_base_q <= frame_base_d;
      win_base_q   <= win_base_d;
      i_q          <= i_d;
      j_q          <= j_d;
      r_q          <= r_d;
      c_q          <= c_d;
      acc_q        <= acc_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cur_sad_q    <= cur_sad_d;
      low_sad_q    <= low_sad_d;
      best_row_q   <= best_row_d;
      best_col_q   <= best_col_d;
    end
  end

  // Window pixel buffer, written during LOAD.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < BUF_N; k++) win_q[k] <= '0;
    end else if (win_we_s) begin
      win_q[widx_s] <= pix_s;
    end
  end

  assign MemReq     = mem_req_q;
  assign MemAddr    = mem_addr_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign CurrentSAD = cur_sad_q;
  assign LowestSAD  = low_sad_q;
  assign BestRow    = best_row_q;
  assign BestCol    = best_col_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Self-checking bench for sad_search_ctrl: a 16/4 instance driven from a
// memory model with optional random read latency, and a 4/4 instance for the
// single-position case. Results are compared against a direct SAD search.
module tb_sad_search_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Reset, Start, MemReq, MemValid, Busy, Done;
  logic [31:0] FrameBase, WinBase, MemAddr, MemRdData, CurrentSAD, LowestSAD;
  logic [7:0]  BestRow, BestCol;

  logic        Start2, MemReq2, MemValid2, Busy2, Done2;
  logic [31:0] FrameBase2, WinBase2, MemAddr2, MemRdData2, CurrentSAD2, LowestSAD2;
  logic [7:0]  BestRow2, BestCol2;

  sad_search_ctrl #(.FRAME_DIM(16), .WIN_DIM(4), .ADDR_W(32), .PIX_W(8)) dut (
    .Clk(clk), .Reset(Reset), .Start(Start), .FrameBase(FrameBase), .WinBase(WinBase),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemValid(MemValid), .MemRdData(MemRdData),
    .Busy(Busy), .Done(Done), .CurrentSAD(CurrentSAD), .LowestSAD(LowestSAD),
    .BestRow(BestRow), .BestCol(BestCol));

  sad_search_ctrl #(.FRAME_DIM(4), .WIN_DIM(4), .ADDR_W(32), .PIX_W(8)) dut_one (
    .Clk(clk), .Reset(Reset), .Start(Start2), .FrameBase(FrameBase2), .WinBase(WinBase2),
    .MemReq(MemReq2), .MemAddr(MemAddr2), .MemValid(MemValid2), .MemRdData(MemRdData2),
    .Busy(Busy2), .Done(Done2), .CurrentSAD(CurrentSAD2), .LowestSAD(LowestSAD2),
    .BestRow(BestRow2), .BestCol(BestCol2));

  int total = 0;
  int bad = 0;

  logic [31:0] mem [0:1023];
  int          max_dly = 0;
  bit          junk_en = 1'b0;
  int          wait_left = 0;
  int          addr_moves = 0;
  int          bad_hi = 0;
  logic [31:0] hi_exp = 32'd0;
  bit          pending = 1'b0;
  logic [31:0] pend_addr = 32'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model for the main instance: random latency, optional junk MemValid when idle.
  always @(negedge clk) begin
    if (Reset === 1'b1) begin
      MemValid  = 1'b0;
      wait_left = 0;
      pending   = 1'b0;
    end else if (MemReq === 1'b1) begin
      if (pending && MemAddr !== pend_addr) addr_moves++;
      if (MemAddr[31:10] !== hi_exp[31:10]) bad_hi++;
      if (wait_left == 0) begin
        MemValid  = 1'b1;
        MemRdData = mem[MemAddr[9:0]];
        pending   = 1'b0;
        wait_left = (max_dly > 0) ? $urandom_range(0, max_dly) : 0;
      end else begin
        MemValid  = 1'b0;
        MemRdData = $urandom;
        wait_left--;
        pending   = 1'b1;
        pend_addr = MemAddr;
      end
    end else begin
      pending   = 1'b0;
      MemValid  = junk_en && ($urandom_range(0, 1) == 1);
      MemRdData = $urandom;
    end
  end

  // Zero-wait memory for the single-position instance: frame 0xFF at 0..15, window 0x00 at 16..31.
  always @(negedge clk) begin
    MemValid2  = (MemReq2 === 1'b1);
    MemRdData2 = (MemAddr2 < 32'd16) ? 32'h0000_00FF : 32'hFFFF_FF00;
  end

  // Direct exhaustive search over the frame in memory.
  task automatic ref_search(input logic [31:0] fb, input logic [31:0] wb,
                            output logic [31:0] low, output logic [31:0] last,
                            output logic [7:0] br, output logic [7:0] bc);
    int sad, a, b;
    logic [31:0] fa, wa;
    low = 32'hFFFF_FFFF; last = 32'd0; br = 8'd0; bc = 8'd0;
    for (int r = 0; r < 13; r++) begin
      for (int c = 0; c < 13; c++) begin
        sad = 0;
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) begin
            fa = fb + 32'((r + i) * 16 + c + j);
            wa = wb + 32'(i * 4 + j);
            a = int'(mem[fa[9:0]][7:0]);
            b = int'(mem[wa[9:0]][7:0]);
            sad += (a > b) ? (a - b) : (b - a);
          end
        end
        last = 32'(sad);
        if (32'(sad) < low) begin
          low = 32'(sad); br = 8'(r); bc = 8'(c);
        end
      end
    end
  endtask

  task automatic check_results(input string tag, input logic [31:0] fb, input logic [31:0] wb);
    logic [31:0] low, last;
    logic [7:0]  br, bc;
    ref_search(fb, wb, low, last, br, bc);
    check_val({tag, ".lowest"}, LowestSAD, low);
    check_val({tag, ".row"}, 32'(BestRow), 32'(br));
    check_val({tag, ".col"}, 32'(BestCol), 32'(bc));
    check_val({tag, ".current"}, CurrentSAD, last);
  endtask

  // Frame pixel (r,c) = (r*16+c)&0xFF; window copied from frame at (3,5).
  task automatic fill_pattern(input logic [31:0] fb, input logic [31:0] wb);
    logic [31:0] a;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        a = fb + 32'(r * 16 + c);
        mem[a[9:0]] = {24'hA5A5A5, 8'((r * 16 + c) & 255)};
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a = wb + 32'(i * 4 + j);
        mem[a[9:0]] = {24'h3C3C3C, 8'(((3 + i) * 16 + 5 + j) & 255)};
      end
  endtask

  task automatic fill_const(input logic [31:0] fb, input logic [31:0] wb,
                            input logic [7:0] fv, input logic [7:0] wv);
    logic [31:0] a;
    for (int k = 0; k < 256; k++) begin
      a = fb + 32'(k);
      mem[a[9:0]] = {24'hABCDEF, fv};
    end
    for (int k = 0; k < 16; k++) begin
      a = wb + 32'(k);
      mem[a[9:0]] = {24'h123456, wv};
    end
  endtask

  task automatic fill_random(input logic [31:0] fb, input logic [31:0] wb);
    logic [31:0] a;
    for (int k = 0; k < 256; k++) begin
      a = fb + 32'(k);
      mem[a[9:0]] = $urandom;
    end
    for (int k = 0; k < 16; k++) begin
      a = wb + 32'(k);
      mem[a[9:0]] = $urandom;
    end
  endtask

  // One search on the main instance; lat = edges from Start sampling to Done visible.
  task automatic run_search(input string tag, input logic [31:0] fb, input logic [31:0] wb,
                            input bit spam, output int lat);
    int n;
    bit seen;
    @(negedge clk);
    FrameBase = fb; WinBase = wb; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    n = 0; seen = 1'b0; lat = -1;
    while (!seen && n < 60000) begin
      @(negedge clk);
      if (spam) begin
        Start = 1'($urandom_range(0, 1));
        FrameBase = $urandom; WinBase = $urandom;
      end
      @(posedge clk); #1;
      n++;
      if (Done === 1'b1) begin
        seen = 1'b1; lat = n;
      end
    end
    check_val({tag, ".done_seen"}, 32'(seen), 32'd1);
    check_val({tag, ".busy_at_done"}, 32'(Busy), 32'd1);
    @(negedge clk);
    Start = spam;
    @(posedge clk); #1;
    Start = 1'b0;
    check_val({tag, ".done_pulse"}, 32'(Done), 32'd0);
    check_val({tag, ".busy_after"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    int lat, n, busy_cnt, done_cnt;
    logic [31:0] fb, wb, hi, tmp;

    Reset = 1'b1; Start = 1'b0; FrameBase = 32'd0; WinBase = 32'd0;
    Start2 = 1'b0; FrameBase2 = 32'd0; WinBase2 = 32'd16;
    for (int k = 0; k < 1024; k++) mem[k] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.memreq", 32'(MemReq), 32'd0);
    check_val("rst.busy", 32'(Busy), 32'd0);
    check_val("rst.done", 32'(Done), 32'd0);
    check_val("rst.memaddr", MemAddr, 32'd0);
    check_val("rst.current", CurrentSAD, 32'd0);
    check_val("rst.lowest", LowestSAD, 32'hFFFF_FFFF);
    check_val("rst.row", 32'(BestRow), 32'd0);
    check_val("rst.col", 32'(BestCol), 32'd0);
    @(negedge clk);
    Reset = 1'b0;

    // Exact match at (3,5), zero-wait memory.
    fb = 32'h100; wb = 32'h020; hi_exp = 32'd0;
    fill_pattern(fb, wb);
    run_search("t1", fb, wb, 1'b0, lat);
    check_val("t1.latency", 32'(lat), 32'(16 + 169 * 17 + 1));
    check_results("t1", fb, wb);
    check_val("t1.lowest_zero", LowestSAD, 32'd0);

    // Flat frame and window: every position ties at 32.
    fill_const(fb, wb, 8'h10, 8'h12);
    run_search("t2", fb, wb, 1'b0, lat);
    check_results("t2", fb, wb);
    check_val("t2.current32", CurrentSAD, 32'd32);

    // Test-1 data with random read latency, junk MemValid while idle and high base bits.
    tmp = $urandom; hi = tmp & 32'hFFFF_FC00;
    fb = hi + 32'h100; wb = hi + 32'h040; hi_exp = hi;
    fill_pattern(fb, wb);
    max_dly = 5; junk_en = 1'b1;
    run_search("t3", fb, wb, 1'b0, lat);
    check_results("t3", fb, wb);
    check_val("t3.addr_stable", 32'(addr_moves), 32'd0);
    check_val("t3.addr_high", 32'(bad_hi), 32'd0);
    max_dly = 0; junk_en = 1'b0;

    // Reset during SCAN of position (6,2), then a clean rerun.
    fb = 32'h100; wb = 32'h020; hi_exp = 32'd0;
    fill_pattern(fb, wb);
    @(negedge clk);
    FrameBase = fb; WinBase = wb; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (1380) @(posedge clk);
    #1;
    check_val("t4.mid_lowest", LowestSAD, 32'd0);
    check_val("t4.mid_row", 32'(BestRow), 32'd3);
    @(negedge clk);
    Reset = 1'b1;
    @(posedge clk); #1;
    check_val("t4.busy", 32'(Busy), 32'd0);
    check_val("t4.memreq", 32'(MemReq), 32'd0);
    check_val("t4.lowest", LowestSAD, 32'hFFFF_FFFF);
    check_val("t4.done", 32'(Done), 32'd0);
    @(negedge clk);
    Reset = 1'b0;
    run_search("t4r", fb, wb, 1'b0, lat);
    check_val("t4r.latency", 32'(lat), 32'(16 + 169 * 17 + 1));
    check_results("t4r", fb, wb);

    // Start pulsed while busy and in the Done cycle: exactly one search.
    run_search("t5", fb, wb, 1'b1, lat);
    check_val("t5.latency", 32'(lat), 32'(16 + 169 * 17 + 1));
    check_results("t5", fb, wb);
    busy_cnt = 0; done_cnt = 0;
    for (n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (Busy === 1'b1) busy_cnt++;
      if (Done === 1'b1) done_cnt++;
    end
    check_val("t5.no_restart", 32'(busy_cnt), 32'd0);
    check_val("t5.one_done", 32'(done_cnt), 32'd0);

    // Random data, random bases, random latency and zero-wait.
    for (int t = 0; t < 2; t++) begin
      tmp = $urandom; hi = tmp & 32'hFFFF_FC00;
      fb = hi + 32'h100 + 32'($urandom_range(0, 255));
      wb = hi + 32'($urandom_range(0, 192));
      hi_exp = hi;
      fill_random(fb, wb);
      max_dly = (t == 0) ? 2 : 0;
      junk_en = 1'b1;
      run_search("rnd", fb, wb, 1'b0, lat);
      check_results("rnd", fb, wb);
      if (t == 1) check_val("rnd.latency", 32'(lat), 32'(16 + 169 * 17 + 1));
    end
    check_val("all.addr_stable", 32'(addr_moves), 32'd0);
    check_val("all.addr_high", 32'(bad_hi), 32'd0);

    // Single position: frame 0xFF, window 0x00.
    @(negedge clk);
    Start2 = 1'b1;
    @(posedge clk); #1;
    Start2 = 1'b0;
    n = 0; lat = -1;
    while (lat < 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (Done2 === 1'b1) lat = n;
    end
    check_val("t6.latency", 32'(lat), 32'd34);
    check_val("t6.lowest", LowestSAD2, 32'd4080);
    check_val("t6.current", CurrentSAD2, 32'd4080);
    check_val("t6.row", 32'(BestRow2), 32'd0);
    check_val("t6.col", 32'(BestCol2), 32'd0);
    check_val("t6.busy", 32'(Busy2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
